// File: rtl/multicycle_logic_unit.sv
// multicycle_logic_unit
//
// Handshaked execute-stage logic unit. ADD, SUB, AND, OR and XOR finish in
// one cycle; unsigned MUL runs shift-and-add over WIDTH cycles. The result
// and its flags are held in registers until the consumer takes them.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operation and operands valid this cycle
//   in_ready   unit can accept an operation (IDLE only)
//   A, B       operands, WIDTH bits
//   c_in       carry in, ADD only
//   oper       000 ADD, 001 AND, 010 OR, 011 XOR, 100 SUB, 101 MUL,
//              110/111 illegal
//   sign       signed overflow rules for ADD/SUB
//   out_valid  result registers hold a completed result
//   out_ready  consumer takes the result this cycle
//   out        registered result
//   OF         registered overflow flag
//   c_out      registered carry flag
//   err        registered illegal-operation flag
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for an operation; in_ready high
// ST_MUL  | shift-and-add multiply in progress, one iteration per cycle
// ST_DONE | result registers valid; held until out_ready

module multicycle_logic_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
    input  logic [2:0]       oper,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             OF,
    output logic             c_out,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;

    logic [2*WIDTH-1:0] acc_next;
    logic               mul_last;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_sum;

    logic [WIDTH-1:0]   alu_out;
    logic               alu_of;
    logic               alu_c;
    logic               alu_err;

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

    // Final iteration is the one where the counter still reads WIDTH-1;
    // its accumulator update is what gets presented.
    assign mul_last = (cnt_q == CW'(WIDTH - 1));
    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    assign add_sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, c_in};
    assign sub_sum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = (oper == OP_MUL) ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_out = '0;
        alu_of  = 1'b0;
        alu_c   = 1'b0;
        alu_err = 1'b0;
        case (oper)
            OP_ADD: begin
                alu_out = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_of  = sign ? ((A[WIDTH-1] == B[WIDTH-1]) &&
                                  (add_sum[WIDTH-1] != A[WIDTH-1]))
                               : add_sum[WIDTH];
            end
            OP_SUB: begin
                // carry out high means no borrow
                alu_out = sub_sum[WIDTH-1:0];
                alu_c   = sub_sum[WIDTH];
                alu_of  = sign ? ((A[WIDTH-1] != B[WIDTH-1]) &&
                                  (sub_sum[WIDTH-1] != A[WIDTH-1]))
                               : ~sub_sum[WIDTH];
            end
            OP_AND:  alu_out = A & B;
            OP_OR:   alu_out = A | B;
            OP_XOR:  alu_out = A ^ B;
            OP_MUL:  alu_out = '0;
            default: alu_err = 1'b1;
        endcase
    end

    // Result registers only load on a completing transition; in IDLE and
    // MUL they keep the previous result and out_valid is the sole qualifier.
    always_ff @(posedge clk) begin
        if (rst) begin
            out      <= '0;
            OF       <= 1'b0;
            c_out    <= 1'b0;
            err      <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (oper == OP_MUL) begin
                            mcand_q  <= {{WIDTH{1'b0}}, A};
                            mplier_q <= B;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                        end else begin
                            out   <= alu_out;
                            OF    <= alu_of;
                            c_out <= alu_c;
                            err   <= alu_err;
                        end
                    end
                end
                ST_MUL: begin
                    acc_q    <= acc_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (mul_last) begin
                        out   <= acc_next[WIDTH-1:0];
                        OF    <= |acc_next[2*WIDTH-1:WIDTH];
                        c_out <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
